// File: rtl/global_pkg.sv
// Project-wide constants shared by all blocks.
package global_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/uart_pkg.sv
// UART shared types and default timing constants.
package uart_pkg;

    localparam int unsigned UART_BAUD_DIV   = 434;
    localparam int unsigned UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        TxaIdle,
        TxaGrant,
        TxaLoad,
        TxaSend,
        TxaGuard
    } TXA_STATE_e;

endpackage

// File: rtl/baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled and pulses tick on the last count.
module baud_gen #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between two byte requesters;
// paces each frame with the baud counter and an idle guard time.
module uart_tx_arbiter
    import uart_pkg::*, global_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = UART_BAUD_DIV,
    parameter int unsigned FRAME_BITS = UART_FRAME_BITS,
    parameter int unsigned GUARD_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic [7:0] tx_data,
    output logic       transmit,
    output logic       baud_tick,
    output logic       busy
);

    TXA_STATE_e state;
    logic       last_gnt;
    logic       win;
    logic       pick;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_inc;
    logic       tick;

    // 1 selects requester 1; on a tie the one not served last wins
    assign pick        = (req0 && req1) ? ~last_gnt : req1;
    assign bit_cnt_inc = bit_cnt + 4'd1;

    baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == TxaLoad),
        .enable ((state == TxaSend) || (state == TxaGuard)),
        .tick   (tick)
    );

    assign baud_tick = tick && (state == TxaSend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TxaIdle;
            last_gnt <= 1'b1;
            win      <= 1'b0;
            bit_cnt  <= 4'd0;
            tx_data  <= 8'h00;
            gnt0     <= FALSE;
            gnt1     <= FALSE;
            transmit <= FALSE;
            busy     <= FALSE;
        end else begin
            gnt0     <= FALSE;
            gnt1     <= FALSE;
            transmit <= FALSE;
            case (state)
                TxaIdle: begin
                    if (req0 || req1) begin
                        win   <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        busy  <= TRUE;
                        state <= TxaGrant;
                    end
                end
                TxaGrant: begin
                    tx_data  <= win ? data1 : data0;
                    last_gnt <= win;
                    transmit <= TRUE;
                    state    <= TxaLoad;
                end
                TxaLoad: begin
                    bit_cnt <= 4'd0;
                    state   <= TxaSend;
                end
                TxaSend: begin
                    if (tick) begin
                        if (bit_cnt_inc == 4'(FRAME_BITS)) begin
                            bit_cnt <= 4'd0;
                            if (GUARD_BITS != 0) begin
                                state <= TxaGuard;
                            end else begin
                                busy  <= FALSE;
                                state <= TxaIdle;
                            end
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                end
                TxaGuard: begin
                    if (tick) begin
                        if (bit_cnt_inc == 4'(GUARD_BITS)) begin
                            bit_cnt <= 4'd0;
                            busy    <= FALSE;
                            state   <= TxaIdle;
                        end else begin
                            bit_cnt <= bit_cnt_inc;
                        end
                    end
                end
                default: begin
                    busy  <= FALSE;
                    state <= TxaIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences and a
// randomized run against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int B = 4;
    localparam int F = 11;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] eg;   // {gnt1, gnt0}
        logic [7:0] etx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;

    logic g0_a, g1_a, tr_a, bt_a, bz_a;
    logic g0_b, g1_b, tr_b, bt_b, bz_b;
    logic [7:0] tx_a, tx_b;

    // sel=0 observes the guarded instance, sel=1 the no-guard instance
    logic sel = 1'b0;
    logic g0, g1, tr, bt, bz;
    logic [7:0] txd;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(.BAUD_DIV(B), .FRAME_BITS(F), .GUARD_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .gnt0(g0_a),
        .req1(req1), .data1(data1), .gnt1(g1_a), .tx_data(tx_a),
        .transmit(tr_a), .baud_tick(bt_a), .busy(bz_a)
    );

    uart_tx_arbiter #(.BAUD_DIV(B), .FRAME_BITS(F), .GUARD_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .gnt0(g0_b),
        .req1(req1), .data1(data1), .gnt1(g1_b), .tx_data(tx_b),
        .transmit(tr_b), .baud_tick(bt_b), .busy(bz_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        g0  = sel ? g0_b : g0_a;
        g1  = sel ? g1_b : g1_a;
        tr  = sel ? tr_b : tr_a;
        bt  = sel ? bt_b : bt_a;
        bz  = sel ? bz_b : bz_a;
        txd = sel ? tx_b : tx_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drain(input int n);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request from idle; measures the whole frame timeline.
    task automatic run_vec(input string nm, input vec_t v, input int gb);
        int occ = 2 + (F + gb) * B;
        int t_gnt = -1, t_tr = -1, t_bt = -1, t_lt = -1, t_fall = -1, nt = 0;
        logic [1:0] gw = 2'b00;
        logic [7:0] tx_at = 8'h00;
        logic bz_gnt = 1'b0;
        @(posedge clk);
        #1 req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
        for (int i = 1; i <= occ + 4; i++) begin
            @(posedge clk);
            #1;
            if (t_gnt > 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            @(negedge clk);
            if ((g0 || g1) && t_gnt < 0) begin t_gnt = i; gw = {g1, g0}; bz_gnt = bz; end
            if (tr && t_tr < 0) begin t_tr = i; tx_at = txd; end
            if (bt) begin nt++; t_lt = i; if (t_bt < 0) t_bt = i; end
            if (!bz && t_gnt > 0 && t_fall < 0) t_fall = i;
        end
        check({nm, "_gnt_time"}, t_gnt, 1);
        check({nm, "_gnt_who"}, {30'd0, gw}, {30'd0, v.eg});
        check({nm, "_busy_at_gnt"}, {31'd0, bz_gnt}, 1);
        check({nm, "_transmit_time"}, t_tr, 2);
        check({nm, "_tx_data"}, {24'd0, tx_at}, {24'd0, v.etx});
        check({nm, "_first_tick"}, t_bt, 2 + B);
        check({nm, "_tick_count"}, nt, F);
        check({nm, "_busy_fall"}, t_fall, 1 + occ);
        check({nm, "_last_tick"}, t_lt, 1 + occ - 1 - gb * B);
    endtask

    // Requests held high continuously: three grants, grant-to-grant period and order.
    task automatic b2b(input string nm, input logic r0v, input logic r1v,
                       input logic [7:0] d0v, input logic [7:0] d1v, input int occ,
                       input logic [2:0] ew, input logic [23:0] etx);
        int tg[3];
        logic w[3];
        logic [7:0] tx[3];
        int n = 0, m = 0;
        do_reset();
        @(posedge clk);
        #1 req0 = r0v; req1 = r1v; data0 = d0v; data1 = d1v;
        for (int i = 1; i <= 3 * (occ + 1) + 6 && m < 3; i++) begin
            @(negedge clk);
            if ((g0 || g1) && n < 3) begin tg[n] = i; w[n] = g1; n++; end
            if (tr && m < 3) begin tx[m] = txd; m++; end
        end
        check({nm, "_grants"}, n, 3);
        check({nm, "_transmits"}, m, 3);
        for (int k = 0; k < n; k++) check({nm, "_winner"}, {31'd0, w[k]}, {31'd0, ew[k]});
        for (int k = 0; k < m; k++) check({nm, "_tx"}, {24'd0, tx[k]}, {24'd0, etx[8*k +: 8]});
        // period = frame occupancy plus the one IDLE cycle in which the request is sampled
        for (int k = 1; k < n; k++) check({nm, "_period"}, tg[k] - tg[k-1], occ + 1);
        drain(60);
    endtask

    // Cycle-level reference from the frame timeline: offset o from the GRANT cycle fixes
    // every output; a new grant follows any idle cycle with a pending request.
    task automatic random_run(input int ncyc, input int gb);
        int occ = 2 + (F + gb) * B;
        int g = -100000;
        int o;
        logic w = 1'b0, last = 1'b1;
        logic [7:0] cap = 8'h00, txe = 8'h00;
        logic pr0 = 1'b0, pr1 = 1'b0, sg0 = 1'b0, sg1 = 1'b0;
        logic [7:0] pd0 = 8'h00, pd1 = 8'h00;
        logic [12:0] ev, av;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            if (req0 && sg0) begin
                req0 = 1'($urandom_range(0, 1));
                data0 = 8'($urandom);
            end else if (!req0 && $urandom_range(0, 7) == 0) begin
                req0 = 1'b1;
                data0 = 8'($urandom);
            end
            if (req1 && sg1) begin
                req1 = 1'($urandom_range(0, 1));
                data1 = 8'($urandom);
            end else if (!req1 && $urandom_range(0, 7) == 0) begin
                req1 = 1'b1;
                data1 = 8'($urandom);
            end
            @(negedge clk);
            if ((c - 1 - g >= occ) && (pr0 || pr1)) begin
                w = (pr0 && pr1) ? ~last : pr1;
                last = w;
                g = c;
                cap = w ? pd1 : pd0;
            end
            o = c - g;
            if (o == 1) txe = cap;
            ev = {o == 0 && !w, o == 0 && w, o == 1,
                  o > 1 && o <= 1 + F * B && (o - 1) % B == 0,
                  o < occ, txe};
            av = {g0, g1, tr, bt, bz, txd};
            check(gb != 0 ? "rand_guard_cycle" : "rand_noguard_cycle", {19'd0, av}, {19'd0, ev});
            sg0 = g0; sg1 = g1;
            pr0 = req0; pr1 = req1;
            pd0 = data0; pd1 = data1;
        end
        drain(60);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int nt, tf, tg;
        logic sg;
        logic [1:0] gw;

        vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 2'b01, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'b10, 8'h22};
        vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'b01, 8'h11};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h3C, 2'b10, 8'h3C};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hC3, 2'b10, 8'hC3};
        vecs[5] = '{1'b1, 1'b1, 8'h5A, 8'hA5, 2'b01, 8'h5A};
        vecs[6] = '{1'b1, 1'b1, 8'hFF, 8'h00, 2'b10, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 8'h80, 8'h7F, 2'b01, 8'h80};

        repeat (2) @(negedge clk);
        check("reset_hold", {6'd0, g0_a, g1_a, tr_a, bt_a, bz_a, tx_a, g0_b, g1_b, tr_b, bt_b,
                             bz_b, tx_b}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_release", {6'd0, g0_a, g1_a, tr_a, bt_a, bz_a, tx_a, g0_b, g1_b, tr_b,
                                bt_b, bz_b, tx_b}, 32'd0);

        sel = 1'b0;
        for (int i = 0; i < 8; i++) run_vec("vec_guard", vecs[i], 1);
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 3; i++) run_vec("vec_noguard", vecs[i], 0);

        sel = 1'b0;
        b2b("b2b_both", 1'b1, 1'b1, 8'h11, 8'h22, 2 + (F + 1) * B, 3'b010, 24'h112211);
        sel = 1'b1;
        b2b("b2b_noguard", 1'b1, 1'b0, 8'h5A, 8'h00, 2 + F * B, 3'b000, 24'h5A5A5A);

        // req1 rises mid-frame and must wait for the first idle cycle
        sel = 1'b0;
        do_reset();
        @(posedge clk);
        #1 req0 = 1'b1; data0 = 8'hC3;
        nt = 0; tf = -1; tg = -1; sg = 1'b0;
        for (int i = 1; i < 90 && tg < 0; i++) begin
            @(posedge clk);
            #1;
            if (sg) req0 = 1'b0;
            if (nt >= 5 && !req1) begin req1 = 1'b1; data1 = 8'h3C; end
            @(negedge clk);
            if (g0) sg = 1'b1;
            if (bt) nt++;
            if (req1 && !bz && tf < 0) tf = i;
            if (g1 && tg < 0) tg = i;
        end
        check("busy_req_gnt_seen", {31'd0, tg > 0}, 1);
        check("busy_req_gnt_time", tg, tf + 1);
        drain(60);

        // asynchronous reset mid-frame, then a tie goes to requester 0
        do_reset();
        @(posedge clk);
        #1 req0 = 1'b1; data0 = 8'h96;
        nt = 0;
        for (int i = 0; i < 60 && nt < 5; i++) begin
            @(negedge clk);
            if (bt) nt++;
        end
        check("midreset_ticks_reached", nt, 5);
        rst = 1'b0;
        #1;
        check("midreset_outputs", {27'd0, bz, bt, tr, g0, g1}, 32'd0);
        check("midreset_tx_data", {24'd0, txd}, 32'd0);
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h02;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        gw = 2'b00;
        for (int i = 0; i < 6 && gw == 2'b00; i++) begin
            @(negedge clk);
            gw = {g1, g0};
        end
        check("midreset_first_winner", {30'd0, gw}, 32'd1);
        drain(60);

        sel = 1'b0;
        do_reset();
        random_run(1500, 1);
        sel = 1'b1;
        do_reset();
        random_run(1000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
